logip_tx: RTL and testbench

Sample readout transmitter for the logIP logic analyzer. Accepts one sample word per strobe from the capture controller's transmit handshake (`stb`/`rdy`), sends the enabled byte groups of that word LSB-group first over an 8N1 UART line, and reports ready when the last stop bit has finished. Sits between the controller's readout path and the host-facing serial pin. It is the sending end of the controller's `tx_stb`/`tx_sel`/`tx_rdy` interface.

---
 rtl/logip_pkg.sv | 22 ++
 rtl/logip_uart_byte.sv | 71 +++++++
 rtl/logip_tx.sv | 87 ++++++++
 tb/tb_logip_tx.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/logip_pkg.sv
// Shared types, constants and helpers for the logIP sample readout path.
package logip_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    SEND
  } tx_state_t;

  localparam int UART_DATA_BITS = 8;
  localparam int MAX_GROUPS     = 32;
  localparam int GROUP_IDX_W    = 5;

  // Scanning from the top down leaves the lowest set index as the final value.
  function automatic logic [GROUP_IDX_W-1:0] lowest_set(input logic [MAX_GROUPS-1:0] mask);
    lowest_set = '0;
    for (int i = MAX_GROUPS - 1; i >= 0; i--) begin
      if (mask[i]) lowest_set = GROUP_IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/logip_uart_byte.sv
// Serializes one byte as a UART frame: start, 8 data bits LSB first, optional parity, stop.
// Optional even parity bit enabled by defining LOGIP_TX_PARITY_EN.
module logip_uart_byte
  import logip_pkg::*;
#(
  parameter int CLK_PER_BIT = 868
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] byte_i,
  output logic       tx_o,
  output logic       done_o
);

`ifdef LOGIP_TX_PARITY_EN
  localparam int FRAME_BITS = UART_DATA_BITS + 3;
`else
  localparam int FRAME_BITS = UART_DATA_BITS + 2;
`endif
  localparam int DIV_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_PER_BIT - 1);
  localparam logic [3:0]       BIT_LAST = 4'(FRAME_BITS - 1);

  logic [FRAME_BITS-1:0] frame_load;
  logic [FRAME_BITS-1:0] frame_reg;
  logic [DIV_W-1:0]      div_reg;
  logic [3:0]            bit_reg;
  logic                  busy_reg;
  logic                  tx_reg;

`ifdef LOGIP_TX_PARITY_EN
  assign frame_load = {1'b1, ^byte_i, byte_i, 1'b0};
`else
  assign frame_load = {1'b1, byte_i, 1'b0};
`endif

  // frame_reg[0] is the bit on the line; ones shift in so the line rests high after stop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_reg <= '1;
      div_reg   <= '0;
      bit_reg   <= '0;
      busy_reg  <= 1'b0;
      tx_reg    <= 1'b1;
    end else if (load_i) begin
      frame_reg <= frame_load;
      div_reg   <= '0;
      bit_reg   <= '0;
      busy_reg  <= 1'b1;
      tx_reg    <= 1'b0;
    end else if (busy_reg) begin
      if (div_reg == DIV_LAST) begin
        div_reg <= '0;
        if (bit_reg == BIT_LAST) begin
          busy_reg <= 1'b0;
        end else begin
          bit_reg   <= bit_reg + 4'd1;
          tx_reg    <= frame_reg[1];
          frame_reg <= {1'b1, frame_reg[FRAME_BITS-1:1]};
        end
      end else begin
        div_reg <= div_reg + DIV_W'(1);
      end
    end
  end

  assign tx_o   = tx_reg;
  assign done_o = busy_reg && (div_reg == DIV_LAST) && (bit_reg == BIT_LAST);

endmodule

// File: rtl/logip_tx.sv
// logIP sample transmitter: sends the enabled byte groups of a sample word over UART.
// Parity build option: LOGIP_TX_PARITY_EN (handled inside logip_uart_byte).
module logip_tx
  import logip_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int CLK_PER_BIT = 868
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stb_i,
  input  logic [WIDTH-1:0]   data_i,
  input  logic [WIDTH/8-1:0] sel_i,
  output logic               rdy_o,
  output logic               tx_o
);

  localparam int G = WIDTH / 8;

  tx_state_t              state_reg, state_next;
  logic [WIDTH-1:0]       word_reg;
  logic [G-1:0]           mask_reg;
  logic [G-1:0]           hit;
  logic [7:0]             group_byte [G];
  logic [7:0]             byte_sel;
  logic [GROUP_IDX_W-1:0] low_idx;
  logic                   load;
  logic                   done;

  assign low_idx = lowest_set(MAX_GROUPS'(mask_reg));

  generate
    for (genvar gi = 0; gi < G; gi++) begin : g_group
      assign group_byte[gi] = word_reg[8*gi +: 8];
      assign hit[gi]        = (low_idx == GROUP_IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_reg <= '0;
      mask_reg <= '0;
    end else if (state_reg == IDLE && stb_i) begin
      word_reg <= data_i;
      mask_reg <= sel_i;
    end else if (load) begin
      mask_reg <= mask_reg & ~hit;
    end
  end

  // The last frame returns straight to IDLE so ready rises in the cycle a SCAN would occupy.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: if (stb_i) state_next = SCAN;
      SCAN: state_next = (mask_reg == '0) ? IDLE : SEND;
      SEND: if (done) state_next = (mask_reg == '0) ? IDLE : SCAN;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rdy_o    = (state_reg == IDLE);
    load     = (state_reg == SCAN) && (mask_reg != '0);
    byte_sel = '0;
    for (int i = 0; i < G; i++) begin
      if (hit[i]) byte_sel = group_byte[i];
    end
  end

  logip_uart_byte #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_uart_byte (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .load_i(load),
    .byte_i(byte_sel),
    .tx_o  (tx_o),
    .done_o(done)
  );

endmodule

// File: tb/tb_logip_tx.sv
// Self-checking bench for logip_tx: behavioural waveform model plus literal timing pins.
module tb_logip_tx;

  localparam int CPB    = 4;
  localparam int WIDTH  = 32;
  localparam int G      = WIDTH / 8;
  localparam int BUDGET = 2000;
`ifdef LOGIP_TX_PARITY_EN
  localparam int FR = 11 * CPB;
`else
  localparam int FR = 10 * CPB;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             stb;
  logic [WIDTH-1:0] data;
  logic [G-1:0]     sel;
  logic             rdy;
  logic             tx;

  int checks   = 0;
  int failures = 0;

  logic hist [0:399];

  always #5 clk = ~clk;

  logip_tx #(
    .WIDTH      (WIDTH),
    .CLK_PER_BIT(CPB)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .stb_i (stb),
    .data_i(data),
    .sel_i (sel),
    .rdy_o (rdy),
    .tx_o  (tx)
  );

  // ---------------- behavioural model ----------------
  int         t_m = -1;
  logic [7:0] q_m [$];

  function automatic int busy_end(input int n);
    return (n == 0) ? 2 : 1 + n * (FR + 1);
  endfunction

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef LOGIP_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  function automatic logic model_tx(input int t);
    int k, r;
    if (t < 2) return 1'b1;
    k = (t - 2) / (FR + 1);
    r = (t - 2) % (FR + 1);
    if (k >= q_m.size() || r >= FR) return 1'b1;
    return frame_bit(q_m[k], r / CPB);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      t_m = -1;
    end else if (t_m < 0) begin
      if (stb) begin
        q_m.delete();
        for (int g = 0; g < G; g++) if (sel[g]) q_m.push_back(data[8*g +: 8]);
        t_m = 1;
      end
    end else begin
      t_m++;
      if (t_m >= busy_end(q_m.size())) t_m = -1;
    end
  end

  always @(negedge clk) begin
    logic et, er;
    if (rst || t_m < 0) begin
      et = 1'b1;
      er = 1'b1;
    end else begin
      et = model_tx(t_m);
      er = 1'b0;
    end
    checks++;
    if (tx !== et) begin
      failures++;
      $display("FAIL model_tx t=%0d got=%b want=%b at %0t", t_m, tx, et, $time);
    end
    checks++;
    if (rdy !== er) begin
      failures++;
      $display("FAIL model_rdy t=%0d got=%b want=%b at %0t", t_m, rdy, er, $time);
    end
  end

  // ---------------- helpers ----------------
  task automatic check_val(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  task automatic check_hist(input string name, input int cyc, input logic want);
    checks++;
    if (hist[cyc] !== want) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%b want=%b", name, cyc, hist[cyc], want);
    end
  endtask

  task automatic wait_ready();
    int w = 0;
    while (rdy !== 1'b1 && w < BUDGET) begin
      @(negedge clk);
      w++;
    end
    if (w >= BUDGET) begin
      checks++;
      failures++;
      $display("FAIL wait_ready timeout got=rdy_low want=rdy_high");
    end
  endtask

  // Called at a negedge; returns after the negedge in which rdy is seen high again.
  task automatic send(input logic [WIDTH-1:0] d, input logic [G-1:0] s, input int exp_rise,
                      input bit spam, input int poke_cyc);
    int c;
    for (int i = 0; i < 400; i++) hist[i] = 1'bx;
    wait_ready();
    stb  = 1'b1;
    data = d;
    sel  = s;
    hist[0] = tx;
    @(negedge clk);
    c = 1;
    stb  = 1'b0;
    data = $urandom;
    sel  = G'($urandom);
    hist[1] = tx;
    while (rdy !== 1'b1 && c < BUDGET) begin
      stb = spam ? 1'($urandom_range(0, 1)) : (c == poke_cyc);
      if (spam || c == poke_cyc) begin
        data = $urandom;
        sel  = G'($urandom);
      end
      @(negedge clk);
      c++;
      if (c < 400) hist[c] = tx;
    end
    stb = 1'b0;
    checks++;
    if (c != exp_rise) begin
      failures++;
      $display("FAIL rdy_rise data=%h sel=%b got=%0d want=%0d", d, s, c, exp_rise);
    end
    $display("txn data=%h sel=%b rdy_rise=%0d", d, s, c);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] pat;
    int         zeros;
    rst  = 1'b1;
    stb  = 1'b0;
    data = '0;
    sel  = '0;
    repeat (3) @(negedge clk);
    check_val("reset_tx", tx, 1'b1);
    check_val("reset_rdy", rdy, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check_val("idle_rdy", rdy, 1'b1);

    // 1: single byte 0x11
    send(32'h44332211, 4'b0001, busy_end(1), 1'b0, -1);
    pat = 8'h11;
    for (int c = 2; c <= 5; c++) check_hist("t1_start", c, 1'b0);
    for (int b = 0; b < 8; b++) check_hist("t1_data", 6 + 4 * b + 1, pat[b]);
`ifndef LOGIP_TX_PARITY_EN
    check_val("t1_rise_lit", 1'(busy_end(1) == 42), 1'b1);
    for (int c = 38; c <= 41; c++) check_hist("t1_stop", c, 1'b1);
`endif

    // 2: four bytes back to back
    send(32'h44332211, 4'b1111, busy_end(4), 1'b0, -1);
    for (int k = 0; k < 4; k++) check_hist("t2_start", 2 + k * (FR + 1), 1'b0);
    for (int k = 1; k < 4; k++) check_hist("t2_gap", 1 + k * (FR + 1), 1'b1);
`ifndef LOGIP_TX_PARITY_EN
    check_hist("t2_byte1_bit1", 43 + 8, 1'b1);
`endif

    // 3: sparse mask sends 0xCC then 0xAA
    send(32'hAABBCCDD, 4'b1010, busy_end(2), 1'b0, -1);
    check_hist("t3_cc_bit0", 6, 1'b0);
    check_hist("t3_cc_bit2", 14, 1'b1);
    check_hist("t3_aa_start", 2 + FR + 1, 1'b0);
    check_hist("t3_aa_bit1", 2 + FR + 1 + 8, 1'b1);

    // 4: empty mask
    send(32'h12345678, 4'b0000, 2, 1'b0, -1);
    check_hist("t4_tx_c1", 1, 1'b1);

    // 5a: stb during a send is ignored
    send(32'h44332211, 4'b0001, busy_end(1), 1'b0, 20);
    for (int b = 0; b < 8; b++) check_hist("t5_data", 6 + 4 * b + 2, pat[b]);

    // 5b: asynchronous reset mid-frame
    wait_ready();
    stb  = 1'b1;
    data = 32'h44332211;
    sel  = 4'b1111;
    @(negedge clk);
    stb = 1'b0;
    for (int c = 1; c < 29; c++) @(negedge clk);
    check_val("t5_busy_before_rst", rdy, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("t5_rst_tx", tx, 1'b1);
    check_val("t5_rst_rdy", rdy, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    zeros = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (tx === 1'b0) zeros++;
    end
    checks++;
    if (zeros != 0) begin
      failures++;
      $display("FAIL t5_no_start got=%0d want=0", zeros);
    end

    // 6: parity pattern byte 0x07
    send(32'h00000007, 4'b0001, busy_end(1), 1'b0, -1);
`ifdef LOGIP_TX_PARITY_EN
    for (int c = 38; c <= 41; c++) check_hist("t6_parity", c, 1'b1);
    for (int c = 42; c <= 45; c++) check_hist("t6_stop", c, 1'b1);
    check_val("t6_rise_lit", 1'(busy_end(1) == 46), 1'b1);
`else
    for (int c = 38; c <= 41; c++) check_hist("t6_stop", c, 1'b1);
`endif

    // randomized traffic, sometimes hammering stb while busy
    for (int n = 0; n < 25; n++) begin
      logic [WIDTH-1:0] d;
      logic [G-1:0]     s;
      d = $urandom;
      s = G'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(d, s, busy_end($countones(s)), 1'($urandom_range(0, 1)), -1);
    end

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
